mul_unit_scheduler: RTL and testbench

//  Shares one multiply issue port across NUM_UNITS iterative multiplier units (each NUM_STAGES+1 cycles, no output backpressure).

---
 rtl/mul_unit_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_mul_unit_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit_scheduler.sv
// Multiply issue scheduler: dispatches uops round-robin across iterative multiplier units,
// holds each unit's result in a one-entry slot and arbitrates the result port oldest-first.
package mul_unit_scheduler_pkg;
  localparam int SQN_W = 7;
  localparam int TAG_W = 6;

  typedef logic [SQN_W-1:0] SqN;
  localparam logic signed [SQN_W-1:0] SQN_ZERO = '0;

  typedef enum logic [1:0] {
    MUL_MUL   = 2'd0,
    MUL_MULH  = 2'd1,
    MUL_MULSU = 2'd2,
    MUL_MULU  = 2'd3
  } MulOp;

  typedef struct packed {
    logic taken;
    SqN   sqN;
  } BranchProv;

  typedef struct packed {
    logic             valid;
    SqN               sqN;
    MulOp             opcode;
    logic [TAG_W-1:0] tagDst;
    logic [31:0]      srcA;
    logic [31:0]      srcB;
  } EX_UOp;

  typedef struct packed {
    logic             valid;
    SqN               sqN;
    logic [TAG_W-1:0] tagDst;
    logic [31:0]      result;
  } RES_UOp;
endpackage

module mul_unit_scheduler
  import mul_unit_scheduler_pkg::*;
#(
  parameter int NUM_UNITS  = 2,
  parameter int NUM_STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 OUT_busy,
  input  BranchProv            IN_branch,
  input  EX_UOp                IN_uop,
  input  logic                 IN_wbStall,
  output logic [NUM_UNITS-1:0] OUT_unitEn,
  output EX_UOp                OUT_unitUop,
  input  logic [NUM_UNITS-1:0] IN_unitBusy,
  input  RES_UOp               IN_unitRes [NUM_UNITS],
  output RES_UOp               OUT_uop
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  // Sequence numbers wrap, so ordering is the sign of the modular difference.
  function automatic logic is_younger(input SqN x, input BranchProv b);
    SqN d;
    d = x - b.sqN;
    return b.taken && ($signed(d) > SQN_ZERO);
  endfunction

  function automatic logic is_older(input SqN a, input SqN b);
    SqN d;
    d = a - b;
    return $signed(d) < SQN_ZERO;
  endfunction

  logic [NUM_UNITS-1:0] r_inflight;
  logic [NUM_UNITS-1:0] r_slot_full;
  SqN                   r_inflight_sqn [NUM_UNITS];
  RES_UOp               r_slot         [NUM_UNITS];
  logic [IDX_W-1:0]     r_rr_ptr;
  RES_UOp               r_out_uop;

  logic [NUM_UNITS-1:0] w_free;
  logic [NUM_UNITS-1:0] w_capture;
  logic [NUM_UNITS-1:0] w_cap_keep;
  logic [NUM_UNITS-1:0] w_inflight_flush;
  logic [NUM_UNITS-1:0] w_slot_flush;
  logic [NUM_UNITS-1:0] w_grant_cand;
  logic [NUM_UNITS-1:0] w_unit_en;
  logic [NUM_UNITS-1:0] w_grant_oh;
  logic [IDX_W-1:0]     w_chosen;
  logic [IDX_W-1:0]     w_rr_next;
  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_grant_any;
  logic                 w_grant;
  logic                 w_busy;
  logic                 w_dispatch;

  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
    assign w_free[gi]           = !r_inflight[gi] && !r_slot_full[gi] && !IN_unitBusy[gi];
    assign w_capture[gi]        = IN_unitRes[gi].valid && r_inflight[gi];
    assign w_cap_keep[gi]       = w_capture[gi] && !is_younger(IN_unitRes[gi].sqN, IN_branch);
    assign w_inflight_flush[gi] = is_younger(r_inflight_sqn[gi], IN_branch);
    assign w_slot_flush[gi]     = is_younger(r_slot[gi].sqN, IN_branch);
    assign w_grant_cand[gi]     = r_slot_full[gi] && !w_slot_flush[gi];

    // Cycles since dispatch, saturating; only feeds the latency check below.
    logic [3:0] r_age;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_age <= '0;
      end else if (w_unit_en[gi]) begin
        r_age <= '0;
      end else if (r_inflight[gi] && r_age != 4'hF) begin
        r_age <= r_age + 4'd1;
      end
    end

    a_result_needs_inflight: assert property (
      @(posedge clk) disable iff (rst) IN_unitRes[gi].valid |-> r_inflight[gi]);

    a_latency_bound: assert property (
      @(posedge clk) disable iff (rst) r_inflight[gi] |-> (32'(r_age) <= NUM_STAGES + 1));
  end

  assign w_busy     = ~|w_free;
  assign w_dispatch = en && IN_uop.valid && !w_busy && !is_younger(IN_uop.sqN, IN_branch);

  // Round-robin pick: first free unit at or after the pointer.
  always_comb begin
    logic found;
    int   idx;
    found    = 1'b0;
    idx      = 0;
    w_chosen = r_rr_ptr;
    for (int i = 0; i < NUM_UNITS; i++) begin
      idx = (int'(r_rr_ptr) + i) % NUM_UNITS;
      if (!found && w_free[idx]) begin
        found    = 1'b1;
        w_chosen = IDX_W'(idx);
      end
    end
  end

  assign w_rr_next = IDX_W'((int'(w_chosen) + 1) % NUM_UNITS);

  always_comb begin
    w_unit_en = '0;
    if (w_dispatch) begin
      w_unit_en[w_chosen] = 1'b1;
    end
  end

  // Oldest surviving slot wins; strict compare keeps ties on the lowest index.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    SqN               best;
    found = 1'b0;
    idx   = '0;
    best  = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (w_grant_cand[u] && (!found || is_older(r_slot[u].sqN, best))) begin
        found = 1'b1;
        idx   = IDX_W'(u);
        best  = r_slot[u].sqN;
      end
    end
    w_grant_any = found;
    w_grant_idx = idx;
  end

  assign w_grant = w_grant_any && !IN_wbStall;

  always_comb begin
    w_grant_oh = '0;
    if (w_grant) begin
      w_grant_oh[w_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight  <= '0;
      r_slot_full <= '0;
      r_rr_ptr    <= '0;
      r_out_uop   <= '0;
    end else begin
      if (w_dispatch) begin
        r_rr_ptr <= w_rr_next;
      end
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (w_unit_en[u]) begin
          r_inflight[u] <= 1'b1;
        end else if (w_capture[u] || w_inflight_flush[u]) begin
          r_inflight[u] <= 1'b0;
        end
        if (w_grant_oh[u] || w_slot_flush[u]) begin
          r_slot_full[u] <= 1'b0;
        end else if (w_cap_keep[u]) begin
          r_slot_full[u] <= 1'b1;
        end
      end
      if (w_grant) begin
        r_out_uop <= r_slot[w_grant_idx];
      end else begin
        r_out_uop.valid <= 1'b0;
      end
    end
  end

  // Payload storage is qualified by the valid bits above, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (w_unit_en[u]) begin
        r_inflight_sqn[u] <= IN_uop.sqN;
      end
      if (w_cap_keep[u]) begin
        r_slot[u] <= IN_unitRes[u];
      end
    end
  end

  assign OUT_busy    = w_busy;
  assign OUT_unitEn  = w_unit_en;
  assign OUT_unitUop = IN_uop;
  assign OUT_uop     = r_out_uop;

endmodule

// File: tb/tb_mul_unit_scheduler.sv
// Directed bench for mul_unit_scheduler: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares every valid OUT_uop.
module tb_mul_unit_scheduler;
  import mul_unit_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       busy;
  BranchProv  br;
  EX_UOp      uop;
  logic       wb_stall;
  logic [1:0] unit_en;
  EX_UOp      unit_uop;
  logic [1:0] unit_busy;
  RES_UOp     unit_res [2];
  RES_UOp     out_uop;

  RES_UOp exp_q [$];
  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mul_unit_scheduler #(.NUM_UNITS(2), .NUM_STAGES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .OUT_busy    (busy),
    .IN_branch   (br),
    .IN_uop      (uop),
    .IN_wbStall  (wb_stall),
    .OUT_unitEn  (unit_en),
    .OUT_unitUop (unit_uop),
    .IN_unitBusy (unit_busy),
    .IN_unitRes  (unit_res),
    .OUT_uop     (out_uop)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
      $display("check %s = %0h", name, act);
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    en          = 1'b0;
    uop         = '0;
    br          = '0;
    unit_res[0] = '0;
    unit_res[1] = '0;
  endtask

  task automatic issue(input SqN s);
    en  = 1'b1;
    uop = '{valid: 1'b1, sqN: s, opcode: MUL_MULH, tagDst: 6'h2A, srcA: 32'd3, srcB: 32'd7};
  endtask

  task automatic result(input int u, input SqN s, input logic [31:0] v);
    unit_res[u] = '{valid: 1'b1, sqN: s, tagDst: s[TAG_W-1:0], result: v};
  endtask

  task automatic expect_out(input SqN s, input logic [31:0] v);
    exp_q.push_back('{valid: 1'b1, sqN: s, tagDst: s[TAG_W-1:0], result: v});
  endtask

  // Monitor: every valid result on the port must match the oldest queued expectation.
  initial begin
    RES_UOp e;
    forever begin
      @(negedge clk);
      if (!rst && out_uop.valid) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL out_unexpected: got sqN=%02h result=%08h, required no output",
                   out_uop.sqN, out_uop.result);
        end else begin
          e = exp_q.pop_front();
          if (out_uop.sqN == e.sqN && out_uop.result == e.result && out_uop.tagDst == e.tagDst) begin
            n_pass++;
            $display("grant sqN=%02h result=%08h", out_uop.sqN, out_uop.result);
          end else begin
            $display("FAIL out_uop: got sqN=%02h tag=%02h result=%08h, required sqN=%02h tag=%02h result=%08h",
                     out_uop.sqN, out_uop.tagDst, out_uop.result, e.sqN, e.tagDst, e.result);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    wb_stall  = 1'b0;
    unit_busy = 2'b00;
    clear_pulses();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_uop.valid, 0);
    check("rst_unit_en", unit_en, 0);
    step();

    // Back-to-back dispatch, then a held uop until unit0's result is granted.
    issue(7'd1); @(negedge clk); check("t1_first_unit0", unit_en, 2'b01); check("t1_busy0", busy, 0); step();
    issue(7'd2); @(negedge clk); check("t1_second_unit1", unit_en, 2'b10); check("t1_pass_uop", unit_uop.sqN, 2); step();
    issue(7'd3); @(negedge clk); check("t1_third_busy", busy, 1); check("t1_third_held", unit_en, 0); step();
    result(0, 7'd1, 32'h0000_1001); expect_out(7'd1, 32'h0000_1001);
    @(negedge clk); check("t1_busy_capture", busy, 1); step();
    unit_res[0] = '0;
    @(negedge clk); check("t1_busy_slot_full", busy, 1); step();
    @(negedge clk); check("t1_free_after_grant", busy, 0); check("t1_third_unit0", unit_en, 2'b01); step();
    clear_pulses();
    result(1, 7'd2, 32'h0000_2002); result(0, 7'd3, 32'h0000_3003);
    expect_out(7'd2, 32'h0000_2002); expect_out(7'd3, 32'h0000_3003);
    step(); clear_pulses(); repeat (3) step();

    // Simultaneous results: lower sqN leaves first.
    issue(7'd5); @(negedge clk); check("t2_unit1", unit_en, 2'b10); step();
    issue(7'd3); @(negedge clk); check("t2_unit0", unit_en, 2'b01); step();
    clear_pulses();
    result(1, 7'd5, 32'h0000_5005); result(0, 7'd3, 32'h0000_3333);
    expect_out(7'd3, 32'h0000_3333); expect_out(7'd5, 32'h0000_5005);
    step(); clear_pulses(); repeat (3) step();

    // Writeback stall with both slots full.
    issue(7'd10); @(negedge clk); check("t3_unit1", unit_en, 2'b10); step();
    issue(7'd11); @(negedge clk); check("t3_unit0", unit_en, 2'b01); step();
    clear_pulses();
    wb_stall = 1'b1;
    result(1, 7'd10, 32'h0000_A00A); result(0, 7'd11, 32'h0000_B00B);
    expect_out(7'd10, 32'h0000_A00A); expect_out(7'd11, 32'h0000_B00B);
    step(); clear_pulses();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("t3_stall_no_out", out_uop.valid, 0); check("t3_stall_busy", busy, 1); step();
    end
    wb_stall = 1'b0;
    repeat (3) step();

    // Branch flushes an inflight younger uop, keeps an older slot, blocks a younger issue.
    issue(7'd2); @(negedge clk); check("t4_unit1", unit_en, 2'b10); step();
    issue(7'd6); @(negedge clk); check("t4_unit0", unit_en, 2'b01); step();
    clear_pulses();
    wb_stall = 1'b1;
    result(1, 7'd2, 32'h0000_2222);
    step(); clear_pulses();
    br = '{taken: 1'b1, sqN: 7'd4}; issue(7'd7);
    @(negedge clk); check("t4_younger_not_sent", unit_en, 0); step();
    clear_pulses();
    @(negedge clk); check("t4_inflight_flushed", busy, 0); step();
    expect_out(7'd2, 32'h0000_2222);
    wb_stall = 1'b0;
    repeat (3) step();

    // Slot flush, younger issue blocked with a free unit, older issue allowed.
    issue(7'd20); @(negedge clk); check("t4b_unit1", unit_en, 2'b10); step();
    clear_pulses();
    wb_stall = 1'b1;
    result(1, 7'd20, 32'h0000_2020);
    step(); clear_pulses();
    br = '{taken: 1'b1, sqN: 7'd15}; issue(7'd21);
    @(negedge clk); check("t4b_younger_blocked", unit_en, 0); check("t4b_busy_free", busy, 0); step();
    br = '{taken: 1'b1, sqN: 7'd15}; issue(7'd14);
    @(negedge clk); check("t4b_older_sent", unit_en, 2'b01); step();
    clear_pulses();
    wb_stall = 1'b0;
    @(negedge clk); check("t4b_slot_flushed", busy, 0); step();
    result(0, 7'd14, 32'h0000_1414); expect_out(7'd14, 32'h0000_1414);
    step(); clear_pulses(); repeat (2) step();

    // A result that is younger than a branch in its arrival cycle is discarded.
    issue(7'd30); @(negedge clk); check("t4c_unit1", unit_en, 2'b10); step();
    issue(7'd20); @(negedge clk); check("t4c_unit0", unit_en, 2'b01); step();
    clear_pulses();
    result(1, 7'd30, 32'h0000_3030); br = '{taken: 1'b1, sqN: 7'd25};
    step(); clear_pulses();
    @(negedge clk); check("t4c_result_dropped", busy, 0); step();
    result(0, 7'd20, 32'h0000_2020); expect_out(7'd20, 32'h0000_2020);
    step(); clear_pulses(); repeat (2) step();

    // Wrapped sequence numbers: 0x7E precedes 0x01.
    issue(7'h7E); @(negedge clk); check("t5_unit1", unit_en, 2'b10); step();
    issue(7'h01); @(negedge clk); check("t5_unit0", unit_en, 2'b01); step();
    clear_pulses();
    result(1, 7'h7E, 32'h7E7E_0000); result(0, 7'h01, 32'h0101_0000);
    expect_out(7'h7E, 32'h7E7E_0000); expect_out(7'h01, 32'h0101_0000);
    step(); clear_pulses(); repeat (3) step();

    // Unit busy inputs: the pointer skips a busy unit; all busy reports OUT_busy.
    unit_busy = 2'b11;
    @(negedge clk); check("all_units_busy", busy, 1); step();
    unit_busy = 2'b10;
    issue(7'd45); @(negedge clk); check("skip_busy_unit1", unit_en, 2'b01); step();
    clear_pulses(); unit_busy = 2'b00;
    result(0, 7'd45, 32'h0000_4545); expect_out(7'd45, 32'h0000_4545);
    step(); clear_pulses(); repeat (2) step();

    // Reset asserted during a capture with a result on the port.
    issue(7'd41); @(negedge clk); check("t6_unit1", unit_en, 2'b10); step();
    issue(7'd40); @(negedge clk); check("t6_unit0", unit_en, 2'b01); step();
    clear_pulses();
    result(0, 7'd40, 32'h0000_4040);
    step(); clear_pulses();
    step();
    result(1, 7'd41, 32'h0000_4141);
    check("t6_out_before_rst", out_uop.valid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_out_valid", out_uop.valid, 0);
    check("t6_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    clear_pulses();
    rst = 1'b0;
    issue(7'd50); @(negedge clk); check("t6_post_rst_unit0", unit_en, 2'b01); step();
    clear_pulses();
    result(0, 7'd50, 32'h0000_5050); expect_out(7'd50, 32'h0000_5050);
    step(); clear_pulses(); repeat (3) step();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
